// File: rtl/systolic_feeder.sv
// Skewed activation feeder for a 4x4 weight-stationary PE array: ping-pong tile buffer, diagonal stream, flush window.
// Optional stream-cycle counter on perf_cycles is built only when FEEDER_PERF_CNT_EN is defined.
module systolic_feeder #(
  parameter int WIDTH        = 16,
  parameter int FLUSH_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ld_valid,
  output logic                  ld_ready,
  input  logic [3:0][WIDTH-1:0] ld_data,
  output logic [3:0][WIDTH-1:0] out_left,
  output logic [3:0]            out_enable,
  output logic                  busy,
  output logic                  tile_done,
  output logic [31:0]           perf_cycles
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_FLUSH  = 2'd2
  } state_t;

  localparam logic [3:0] FLUSH_LAST = (FLUSH_CYCLES > 0) ? 4'(FLUSH_CYCLES - 1) : 4'd0;

  state_t           state_r, state_s;
  logic [2:0]       cnt_r, cnt_s;
  logic [3:0]       flush_r, flush_s;
  logic             wr_bank_r, rd_bank_r;
  logic [1:0]       bank_full_r;
  logic [1:0]       beat_cnt_r;
  logic [WIDTH-1:0] bank_r [2][4][4];
  logic             load_fire_s, load_last_s, release_s, tile_done_s;

  assign ld_ready    = ~bank_full_r[wr_bank_r];
  assign load_fire_s = ld_valid & ld_ready;
  assign load_last_s = load_fire_s & (beat_cnt_r == 2'd3);

  // Write pointer: row within the tile and which bank is being filled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_bank_r  <= 1'b0;
      beat_cnt_r <= 2'd0;
    end else if (load_fire_s) begin
      beat_cnt_r <= beat_cnt_r + 2'd1;
      if (load_last_s) begin
        wr_bank_r <= ~wr_bank_r;
      end
    end
  end

  // Tile storage; contents are don't-care after reset so no reset branch
  always_ff @(posedge clk) begin
    if (load_fire_s) begin
      for (int e = 0; e < 4; e++) begin
        bank_r[wr_bank_r][beat_cnt_r][e] <= ld_data[e];
      end
    end
  end

  // Bank ownership: a release and a load completion always touch different banks
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bank_full_r <= 2'b00;
      rd_bank_r   <= 1'b0;
    end else begin
      if (release_s) begin
        bank_full_r[rd_bank_r] <= 1'b0;
        rd_bank_r              <= ~rd_bank_r;
      end
      if (load_last_s) begin
        bank_full_r[wr_bank_r] <= 1'b1;
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      cnt_r   <= 3'd0;
      flush_r <= 4'd0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      flush_r <= flush_s;
    end
  end

  // FSM next state; releasing into a full partner bank keeps tiles back-to-back
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    flush_s     = flush_r;
    release_s   = 1'b0;
    tile_done_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bank_full_r[rd_bank_r]) begin
          state_s = ST_STREAM;
          cnt_s   = 3'd0;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_STREAM: begin
        if (cnt_r == 3'd6) begin
          if (FLUSH_CYCLES == 0) begin
            release_s   = 1'b1;
            tile_done_s = 1'b1;
            cnt_s       = 3'd0;
            state_s     = bank_full_r[~rd_bank_r] ? ST_STREAM : ST_IDLE;
          end else begin
            state_s = ST_FLUSH;
            flush_s = 4'd0;
          end
        end else begin
          cnt_s = cnt_r + 3'd1;
        end
      end
      ST_FLUSH: begin
        if (flush_r == FLUSH_LAST) begin
          release_s   = 1'b1;
          tile_done_s = 1'b1;
          cnt_s       = 3'd0;
          state_s     = bank_full_r[~rd_bank_r] ? ST_STREAM : ST_IDLE;
        end else begin
          flush_s = flush_r + 4'd1;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Slot decode: lane i carries row (cnt - i); the same window gates column i's enable
  always_comb begin
    out_left   = '0;
    out_enable = 4'b0000;
    if (state_r == ST_STREAM) begin
      for (int i = 0; i < 4; i++) begin
        if ((cnt_r >= 3'(i)) && (cnt_r <= 3'(i + 3))) begin
          out_left[i]   = bank_r[rd_bank_r][2'(cnt_r - 3'(i))][i];
          out_enable[i] = 1'b1;
        end else begin
          out_left[i]   = '0;
          out_enable[i] = 1'b0;
        end
      end
    end else begin
      out_left   = '0;
      out_enable = 4'b0000;
    end
  end

  assign busy      = (state_r != ST_IDLE);
  assign tile_done = tile_done_s;

`ifdef FEEDER_PERF_CNT_EN
  logic [31:0] perf_r;

  // Cycles spent streaming, free-running with natural wrap
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_r <= 32'd0;
    end else if (state_r == ST_STREAM) begin
      perf_r <= perf_r + 32'd1;
    end else begin
      perf_r <= perf_r;
    end
  end

  assign perf_cycles = perf_r;
`else
  assign perf_cycles = 32'd0;
`endif

endmodule
